// File: rtl/mem_arb.sv
// ---------------------------------------------------------------------------
// mem_arb -- three-requester arbiter in front of a single synchronous RAM port.
//
// Each granted access walks IDLE -> ADDR -> DATA -> RESP, so every transaction
// takes four cycles from the IDLE cycle that samples REQ to the end of RESP.
// Requester 0 = instruction fetch, 1 = data load/store, 2 = loader/debug.
//
// Parameter
//   FIXED_PRIO  0 = round-robin starting after the last grant, 1 = fixed 0>1>2
//
// Ports
//   CK              clock, rising edge
//   RST             synchronous, active-high reset
//   REQ[2:0]        request per requester
//   WE[2:0]         1 = write, 0 = read, qualified by REQ
//   A0..A2          word address per requester
//   WD0..WD2        write data per requester
//   ACK[2:0]        one-hot completion pulse (RESP cycle only)
//   GNT[2:0]        one-hot owner of the memory port, 0 when idle
//   RD[15:0]        read data, valid while ACK is high after a read
//   BUSY            high whenever the FSM is not in IDLE
//   XCNT[15:0]      completed-transaction counter, wraps at 16 bits
//   MA/MWD/MWE      memory address, write data, write enable
//   MRD[15:0]       memory read data, valid the cycle after MA is sampled
// ---------------------------------------------------------------------------
module mem_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        CK,
    input  logic        RST,
    input  logic [2:0]  REQ,
    input  logic [2:0]  WE,
    input  logic [15:0] A0,
    input  logic [15:0] A1,
    input  logic [15:0] A2,
    input  logic [15:0] WD0,
    input  logic [15:0] WD1,
    input  logic [15:0] WD2,
    output logic [2:0]  ACK,
    output logic [2:0]  GNT,
    output logic [15:0] RD,
    output logic        BUSY,
    output logic [15:0] XCNT,
    output logic [15:0] MA,
    output logic [15:0] MWD,
    output logic        MWE,
    input  logic [15:0] MRD
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic FIXED_MODE = (FIXED_PRIO != 0) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic [2:0]  ack_q, ack_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [15:0] rd_q, rd_d;
    logic [15:0] xcnt_q, xcnt_d;
    logic [15:0] ma_q, ma_d;
    logic [15:0] mwd_q, mwd_d;
    logic        mwe_q, mwe_d;
    // MWE drops after ADDR, so the read/write nature of the access is kept here
    // for the DATA-cycle decision on whether to capture MRD.
    logic        wr_q, wr_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  win_s;

    // Winner among the active requests. In round-robin mode the search starts
    // one past the last granted index; the result is only used when REQ != 0.
    function automatic logic [1:0] pick_winner(
        input logic [2:0] req,
        input logic [1:0] last,
        input logic       fixed
    );
        logic [1:0] w;
        w = 2'd0;
        if (fixed) begin
            if (req[0])      w = 2'd0;
            else if (req[1]) w = 2'd1;
            else             w = 2'd2;
        end else begin
            case (last)
                2'd0: begin
                    if (req[1])      w = 2'd1;
                    else if (req[2]) w = 2'd2;
                    else             w = 2'd0;
                end
                2'd1: begin
                    if (req[2])      w = 2'd2;
                    else if (req[0]) w = 2'd0;
                    else             w = 2'd1;
                end
                default: begin
                    if (req[0])      w = 2'd0;
                    else if (req[1]) w = 2'd1;
                    else             w = 2'd2;
                end
            endcase
        end
        return w;
    endfunction

    assign win_s = pick_winner(REQ, last_q, FIXED_MODE);

    // Next-state and next-output logic for the four-phase access sequence.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        gnt_d   = gnt_q;
        rd_d    = rd_q;
        xcnt_d  = xcnt_q;
        ma_d    = ma_q;
        mwd_d   = mwd_q;
        mwe_d   = mwe_q;
        wr_d    = wr_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (REQ != 3'b000) begin
                    // Operands are captured here so later input changes
                    // cannot disturb the access in flight.
                    gnt_d   = 3'(3'b001 << win_s);
                    last_d  = win_s;
                    state_d = S_ADDR;
                    case (win_s)
                        2'd0: begin
                            ma_d  = A0;
                            mwd_d = WD0;
                            mwe_d = WE[0];
                            wr_d  = WE[0];
                        end
                        2'd1: begin
                            ma_d  = A1;
                            mwd_d = WD1;
                            mwe_d = WE[1];
                            wr_d  = WE[1];
                        end
                        default: begin
                            ma_d  = A2;
                            mwd_d = WD2;
                            mwe_d = WE[2];
                            wr_d  = WE[2];
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                // The RAM samples MA/MWD/MWE at the edge closing this cycle.
                mwe_d   = 1'b0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (wr_q) begin
                    rd_d = rd_q;
                end else begin
                    rd_d = MRD;
                end
                ack_d   = gnt_q;
                xcnt_d  = xcnt_q + 16'd1;
                state_d = S_RESP;
            end
            S_RESP: begin
                ack_d   = 3'b000;
                gnt_d   = 3'b000;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ack_q   <= 3'b000;
            gnt_q   <= 3'b000;
            rd_q    <= 16'h0000;
            xcnt_q  <= 16'h0000;
            ma_q    <= 16'h0000;
            mwd_q   <= 16'h0000;
            mwe_q   <= 1'b0;
            wr_q    <= 1'b0;
            last_q  <= 2'd2;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            gnt_q   <= gnt_d;
            rd_q    <= rd_d;
            xcnt_q  <= xcnt_d;
            ma_q    <= ma_d;
            mwd_q   <= mwd_d;
            mwe_q   <= mwe_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign ACK  = ack_q;
    assign GNT  = gnt_q;
    assign RD   = rd_q;
    assign XCNT = xcnt_q;
    assign MA   = ma_q;
    assign MWD  = mwd_q;
    assign MWE  = mwe_q;

endmodule

// File: tb/tb_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_arb -- self-checking bench for mem_arb. Two instances share the
// request inputs: index 0 uses round-robin, index 1 fixed priority. Each has
// its own synchronous RAM model that shares the system reset.
// ---------------------------------------------------------------------------
module tb_mem_arb;

    logic        CK  = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  REQ = 3'b000;
    logic [2:0]  WE  = 3'b000;
    logic [15:0] A0  = 16'h0000;
    logic [15:0] A1  = 16'h0000;
    logic [15:0] A2  = 16'h0000;
    logic [15:0] WD0 = 16'h0000;
    logic [15:0] WD1 = 16'h0000;
    logic [15:0] WD2 = 16'h0000;

    logic [5:0]  ack_v, gnt_v;
    logic [31:0] rd_v, xcnt_v, ma_v, mwd_v;
    logic [1:0]  busy_v, mwe_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CK = ~CK;

    // Power-on contents of every RAM word.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010)      return 16'hBEEF;
        else if (a == 16'h0030) return 16'h3333;
        else                    return ~a;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [15:0] ram [0:65535];
        logic [15:0] mrd;
        bit          init_done = 1'b0;

        mem_arb #(.FIXED_PRIO(k)) u_dut (
            .CK(CK), .RST(RST), .REQ(REQ), .WE(WE),
            .A0(A0), .A1(A1), .A2(A2), .WD0(WD0), .WD1(WD1), .WD2(WD2),
            .ACK(ack_v[k*3 +: 3]), .GNT(gnt_v[k*3 +: 3]), .RD(rd_v[k*16 +: 16]),
            .BUSY(busy_v[k]), .XCNT(xcnt_v[k*16 +: 16]), .MA(ma_v[k*16 +: 16]),
            .MWD(mwd_v[k*16 +: 16]), .MWE(mwe_v[k]), .MRD(mrd)
        );

        // Synchronous RAM; a write on an edge where RST is high is discarded.
        always @(posedge CK) begin
            if (!init_done) begin
                for (int i = 0; i < 65536; i++) ram[i] <= init_val(16'(i));
                init_done <= 1'b1;
            end else if (!RST && mwe_v[k]) begin
                ram[ma_v[k*16 +: 16]] <= mwd_v[k*16 +: 16];
            end
            mrd <= ram[ma_v[k*16 +: 16]];
        end
    end

    function automatic logic [2:0]  ack_of (input int k); return ack_v[k*3 +: 3];   endfunction
    function automatic logic [2:0]  gnt_of (input int k); return gnt_v[k*3 +: 3];   endfunction
    function automatic logic [15:0] rd_of  (input int k); return rd_v[k*16 +: 16];  endfunction
    function automatic logic [15:0] xcnt_of(input int k); return xcnt_v[k*16 +: 16]; endfunction
    function automatic logic [15:0] ma_of  (input int k); return ma_v[k*16 +: 16];  endfunction
    function automatic logic [15:0] mwd_of (input int k); return mwd_v[k*16 +: 16]; endfunction

    function automatic void chk(input string nm, input int k, input logic [15:0] act,
                                input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%s] @%0t: got %h, expected %h", nm, (k == 0) ? "rr" : "fp",
                     $time, act, exp);
        end
    endfunction

    // ---------------- transaction-level reference model ----------------
    int          m_last;
    logic [15:0] m_xcnt [2];
    logic [15:0] m_rd   [2];
    logic [15:0] sh0 [logic [15:0]];
    logic [15:0] sh1 [logic [15:0]];
    logic [2:0]  obs_gnt  [2];
    logic [15:0] obs_rd   [2];
    logic [15:0] obs_xcnt [2];

    function automatic logic [15:0] sh_get(input int k, input logic [15:0] a);
        if (k == 0) return sh0.exists(a) ? sh0[a] : init_val(a);
        else        return sh1.exists(a) ? sh1[a] : init_val(a);
    endfunction

    function automatic void sh_put(input int k, input logic [15:0] a, input logic [15:0] d);
        if (k == 0) sh0[a] = d;
        else        sh1[a] = d;
    endfunction

    // Index that wins given the requests; -1 when nobody asks.
    function automatic int pick(input logic [2:0] r, input int last, input bit fp);
        if (r == 3'b000) return -1;
        for (int s = 1; s <= 3; s++) begin
            int i;
            i = fp ? (s - 1) : ((last + s) % 3);
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        RST = 1'b1;
        REQ = 3'b000;
        WE  = 3'b000;
        @(posedge CK);
        @(posedge CK); #1;
        RST = 1'b0;
        m_last = 2;
        for (int k = 0; k < 2; k++) begin
            m_xcnt[k] = 16'h0000;
            m_rd[k]   = 16'h0000;
        end
    endtask

    task automatic check_reset_values();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ack",  k, 16'(ack_of(k)), 16'h0000);
            chk("rst_gnt",  k, 16'(gnt_of(k)), 16'h0000);
            chk("rst_mwe",  k, 16'(mwe_v[k]),  16'h0000);
            chk("rst_ma",   k, ma_of(k),       16'h0000);
            chk("rst_mwd",  k, mwd_of(k),      16'h0000);
            chk("rst_rd",   k, rd_of(k),       16'h0000);
            chk("rst_xcnt", k, xcnt_of(k),     16'h0000);
            chk("rst_busy", k, 16'(busy_v[k]), 16'h0000);
        end
    endtask

    // One IDLE-sampled request, followed through to the next IDLE cycle.
    // Entered and left #1 after a rising edge with both instances in IDLE.
    task automatic run_txn(input logic [2:0] req, input logic [2:0] we,
                           input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                           input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                           input bit scramble);
        logic [15:0] aa [3];
        logic [15:0] dd [3];
        int          g  [2];
        aa[0] = a0; aa[1] = a1; aa[2] = a2;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        REQ = req; WE = we; A0 = a0; A1 = a1; A2 = a2; WD0 = d0; WD1 = d1; WD2 = d2;
        for (int k = 0; k < 2; k++) g[k] = pick(req, m_last, k == 1);
        @(posedge CK); #1;
        if (scramble) begin
            REQ = 3'($urandom); WE = 3'($urandom);
            A0 = 16'($urandom); A1 = 16'($urandom); A2 = 16'($urandom);
            WD0 = 16'($urandom); WD1 = 16'($urandom); WD2 = 16'($urandom);
        end
        if (g[0] < 0) begin
            for (int k = 0; k < 2; k++) begin
                chk("idle_gnt",  k, 16'(gnt_of(k)), 16'h0000);
                chk("idle_busy", k, 16'(busy_v[k]), 16'h0000);
                obs_gnt[k]  = gnt_of(k);
                obs_rd[k]   = rd_of(k);
                obs_xcnt[k] = xcnt_of(k);
            end
            return;
        end
        m_last = g[0];
        for (int k = 0; k < 2; k++) begin
            chk("addr_gnt",  k, 16'(gnt_of(k)), 16'(3'(3'b001 << g[k])));
            chk("addr_ma",   k, ma_of(k),       aa[g[k]]);
            chk("addr_mwd",  k, mwd_of(k),      dd[g[k]]);
            chk("addr_mwe",  k, 16'(mwe_v[k]),  16'(we[g[k]]));
            chk("addr_busy", k, 16'(busy_v[k]), 16'h0001);
            chk("addr_ack",  k, 16'(ack_of(k)), 16'h0000);
            obs_gnt[k] = gnt_of(k);
        end
        @(posedge CK); #1;
        for (int k = 0; k < 2; k++) begin
            chk("data_mwe", k, 16'(mwe_v[k]),  16'h0000);
            chk("data_ack", k, 16'(ack_of(k)), 16'h0000);
            chk("data_ma",  k, ma_of(k),       aa[g[k]]);
            if (we[g[k]]) sh_put(k, aa[g[k]], dd[g[k]]);
            else          m_rd[k] = sh_get(k, aa[g[k]]);
            m_xcnt[k] = m_xcnt[k] + 16'd1;
        end
        @(posedge CK); #1;
        for (int k = 0; k < 2; k++) begin
            chk("resp_ack",  k, 16'(ack_of(k)), 16'(3'(3'b001 << g[k])));
            chk("resp_gnt",  k, 16'(gnt_of(k)), 16'(3'(3'b001 << g[k])));
            chk("resp_rd",   k, rd_of(k),       m_rd[k]);
            chk("resp_xcnt", k, xcnt_of(k),     m_xcnt[k]);
            chk("resp_mwe",  k, 16'(mwe_v[k]),  16'h0000);
            obs_rd[k]   = rd_of(k);
            obs_xcnt[k] = xcnt_of(k);
        end
        REQ = 3'b000;
        @(posedge CK); #1;
        for (int k = 0; k < 2; k++) begin
            chk("end_ack",  k, 16'(ack_of(k)), 16'h0000);
            chk("end_gnt",  k, 16'(gnt_of(k)), 16'h0000);
            chk("end_busy", k, 16'(busy_v[k]), 16'h0000);
        end
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [15:0] a0, a1, a2;
        logic [15:0] wd0, wd1, wd2;
        logic [2:0]  gnt_rr, gnt_fp;
        logic [15:0] rd_rr, rd_fp;
        logic [15:0] xcnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [2:0] rr_order [6];
        bit         ack_seen;

        //           req     we      a0        a1        a2        wd0       wd1       wd2       g_rr    g_fp    rd_rr     rd_fp     xcnt
        tbl[0] = '{3'b001, 3'b000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001, 3'b001, 16'hBEEF, 16'hBEEF, 16'd1};
        tbl[1] = '{3'b010, 3'b010, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3'b010, 3'b010, 16'hBEEF, 16'hBEEF, 16'd2};
        tbl[2] = '{3'b111, 3'b000, 16'h0040, 16'h0041, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 3'b100, 3'b001, 16'hFFBD, 16'hFFBF, 16'd3};
        tbl[3] = '{3'b111, 3'b000, 16'h0040, 16'h0041, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 3'b001, 3'b001, 16'hFFBF, 16'hFFBF, 16'd4};
        tbl[4] = '{3'b110, 3'b000, 16'h0000, 16'h0020, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 3'b010, 3'b010, 16'h1234, 16'h1234, 16'd5};
        tbl[5] = '{3'b101, 3'b000, 16'h0040, 16'h0000, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 3'b100, 3'b001, 16'hFFBD, 16'hFFBF, 16'd6};
        tbl[6] = '{3'b000, 3'b000, 16'h0040, 16'h0000, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000, 16'hFFBD, 16'hFFBF, 16'd6};
        tbl[7] = '{3'b100, 3'b100, 16'h0000, 16'h0000, 16'h0050, 16'h0000, 16'h0000, 16'hA5A5, 3'b100, 3'b100, 16'hFFBD, 16'hFFBF, 16'd7};
        tbl[8] = '{3'b011, 3'b001, 16'h0051, 16'h0050, 16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 3'b001, 3'b001, 16'hFFBD, 16'hFFBF, 16'd8};
        tbl[9] = '{3'b011, 3'b001, 16'h0051, 16'h0050, 16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 3'b010, 3'b001, 16'hA5A5, 16'hFFBF, 16'd9};

        @(posedge CK); #1;
        apply_reset();
        check_reset_values();

        // Directed vectors from reset.
        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].a2,
                    tbl[i].wd0, tbl[i].wd1, tbl[i].wd2, 1'b0);
            chk("tbl_gnt",  0, 16'(obs_gnt[0]), 16'(tbl[i].gnt_rr));
            chk("tbl_gnt",  1, 16'(obs_gnt[1]), 16'(tbl[i].gnt_fp));
            chk("tbl_rd",   0, obs_rd[0],       tbl[i].rd_rr);
            chk("tbl_rd",   1, obs_rd[1],       tbl[i].rd_fp);
            chk("tbl_xcnt", 0, obs_xcnt[0],     tbl[i].xcnt);
            chk("tbl_xcnt", 1, obs_xcnt[1],     tbl[i].xcnt);
        end

        // All three requesting continuously after a reset.
        apply_reset();
        check_reset_values();
        rr_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 6; i++) begin
            run_txn(3'b111, 3'b000, 16'h0060, 16'h0061, 16'h0062,
                    16'h0000, 16'h0000, 16'h0000, 1'b0);
            chk("rr_order", 0, 16'(obs_gnt[0]), 16'(rr_order[i]));
            chk("fp_order", 1, 16'(obs_gnt[1]), 16'h0001);
        end

        // Reset landing on the ADDR edge of a write to 0x0030.
        apply_reset();
        REQ = 3'b001; WE = 3'b001; A0 = 16'h0030; WD0 = 16'hDEAD;
        @(posedge CK); #1;
        for (int k = 0; k < 2; k++) chk("abort_mwe_pre", k, 16'(mwe_v[k]), 16'h0001);
        RST = 1'b1;
        REQ = 3'b000;
        WE  = 3'b000;
        @(posedge CK); #1;
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("abort_gnt",  k, 16'(gnt_of(k)), 16'h0000);
            chk("abort_busy", k, 16'(busy_v[k]), 16'h0000);
            chk("abort_mwe",  k, 16'(mwe_v[k]),  16'h0000);
            chk("abort_xcnt", k, xcnt_of(k),     16'h0000);
        end
        ack_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge CK); #1;
            if (ack_v != 6'b000000) ack_seen = 1'b1;
        end
        chk("abort_no_ack", 0, 16'(ack_seen), 16'h0000);
        run_txn(3'b001, 3'b000, 16'h0030, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk("abort_mem", 0, obs_rd[0], 16'h3333);
        chk("abort_mem", 1, obs_rd[1], 16'h3333);

        // Randomised traffic, with operands and REQ disturbed after grant.
        for (int i = 0; i < 60; i++) begin
            run_txn(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    16'(16'h0060 + $urandom_range(0, 7)), 16'(16'h0060 + $urandom_range(0, 7)),
                    16'(16'h0060 + $urandom_range(0, 7)),
                    16'($urandom), 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));
        end

        // Counter wrap: preload 0xFFFF instead of issuing 65535 transactions.
        force g_dut[0].u_dut.xcnt_q = 16'hFFFF;
        force g_dut[1].u_dut.xcnt_q = 16'hFFFF;
        @(posedge CK); #1;
        release g_dut[0].u_dut.xcnt_q;
        release g_dut[1].u_dut.xcnt_q;
        for (int k = 0; k < 2; k++) begin
            m_xcnt[k] = 16'hFFFF;
            chk("wrap_pre", k, xcnt_of(k), 16'hFFFF);
        end
        run_txn(3'b001, 3'b000, 16'h0010, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 1'b1);
        chk("wrap_xcnt", 0, obs_xcnt[0], 16'h0000);
        chk("wrap_xcnt", 1, obs_xcnt[1], 16'h0000);
        chk("wrap_rd",   0, obs_rd[0],   16'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
